// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a word-addressed single-port RAM with combinational read.
// Handles byte/half/word loads with sign or zero extension, and sub-word stores via read-modify-write.
module lsu_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic                  uns,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  err_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           word_q;
    logic [31:0]           rdata_q;
    logic                  accept;
    logic                  bad_access;
    logic                  addr_hi_unused;

    // Only the byte offset and the RAM word index are meaningful; the rest wraps.
    assign addr_hi_unused = ^addr[31:ADDR_WIDTH+2];

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                                input logic zext, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic        fill;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: begin
                fill = ~zext & b[7];
                return {{24{fill}}, b};
            end
            SZ_HALF: begin
                fill = ~zext & h[15];
                return {{16{fill}}, h};
            end
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] merged;
        merged = word;
        case (sz)
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = data[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = data[15:0];
            default: merged = data;
        endcase
        return merged;
    endfunction

    assign accept     = (state == IDLE) && req;
    assign bad_access = is_misaligned(size, addr[1:0]);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_access)
                        state_next = DONE;
                    else if (!wr || size != SZ_WORD)
                        state_next = READ;
                    else
                        state_next = WRITE;
                end
            end
            READ:    state_next = wr_q ? WRITE : DONE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_q   <= 1'b0;
            size_q <= 2'b00;
            uns_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                wr_q   <= wr;
                size_q <= size;
                uns_q  <= uns;
                err_q  <= bad_access;
            end
        end
    end

    // Request capture and RAM read capture (data path, not reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr[ADDR_WIDTH+1:0];
            wdata_q <= wdata;
        end
        if (state == READ)
            word_q <= mem_RD;
    end

    // Load result is architecturally visible, so it is reset and held between loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (state == READ && !wr_q)
            rdata_q <= load_extend(mem_RD, size_q, uns_q, addr_q[1:0]);
    end

    assign busy   = state != IDLE;
    assign done   = state == DONE;
    assign err    = done & err_q;
    assign rdata  = rdata_q;
    assign mem_A  = (state != IDLE) ? addr_q[ADDR_WIDTH+1:2] : '0;
    assign mem_we = state == WRITE;
    assign mem_WD = (state == WRITE) ? store_merge(word_q, wdata_q, size_q, addr_q[1:0]) : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, reset/handshake sequences,
// and randomized traffic compared against a byte-array memory model.
module tb_lsu_mem_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          wr = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          uns = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   rdata;
    logic [AW-1:0] mem_A;
    logic [31:0]   mem_WD;
    logic          mem_we;
    logic [31:0]   mem_RD;

    logic [31:0]   ram [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a = '0;
    logic [31:0]   pre_d = '0;

    logic [7:0]    mb [0:4095];
    logic [31:0]   m_rdata;

    int ncmp = 0;
    int nfail = 0;
    int err_nodone = 0;

    lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_A(mem_A), .mem_WD(mem_WD), .mem_we(mem_we), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    assign mem_RD = ram[mem_A];

    always @(posedge clk) begin
        if (mem_we)
            ram[mem_A] <= mem_WD;
        else if (pre_we)
            ram[pre_a] <= pre_d;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        for (int k = 0; k < 4; k++)
            mb[4*idx + k] = val[8*k +: 8];
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = AW'(idx);
        pre_d  = val;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Reference model: byte-addressed memory, operations computed straight from the access rules.
    task automatic model_op(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                            input logic [31:0] d, output logic e, output int lat, output int we);
        int nb;
        int base;
        logic [31:0] v;
        logic [31:0] mask;
        e = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
        lat = 0;
        we = 0;
        if (e) return;
        nb = 1 << s;
        base = int'(a[11:0]);
        if (w) begin
            for (int i = 0; i < nb; i++)
                mb[base + i] = d[8*i +: 8];
            lat = (nb == 4) ? 1 : 2;
            we = 1;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++)
                v[8*i +: 8] = mb[base + i];
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
            if (!u && v[8*nb - 1])
                v = v | ~mask;
            m_rdata = v;
            lat = 1;
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'({a[11:2], 2'b00});
        return {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
    endfunction

    // Issue one request, then scramble the inputs to prove they were registered.
    task automatic do_op(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic e,
                         output logic [31:0] rd, output int wec, output int we_at);
        @(negedge clk);
        req = 1'b1; wr = w; size = s; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; wr = ~w; size = 2'($urandom_range(0, 3)); uns = ~u;
        addr = $urandom(); wdata = $urandom();
        lat = 0; wec = 0; we_at = -1;
        while (done !== 1'b1 && lat < 8) begin
            if (mem_we === 1'b1) begin
                wec++;
                we_at = lat;
            end
            if (err === 1'b1) err_nodone++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (mem_we === 1'b1) wec++;
        e  = err;
        rd = rdata;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        int          lat;
        logic [31:0] rd;
        logic [31:0] word;
        int          we;
    } vec_t;

    vec_t vt [20];

    initial begin
        int          lat, wec, we_at, mlat, mwe, acc, dcnt;
        logic        e, me, prev;
        logic [31:0] rd, a, d;
        logic [9:0]  acc_mask;
        logic [1:0]  s;
        logic        w, u;
        int          r;

        vt[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 1, 32'hFFFF_FFA5, 32'h8000_F0A5, 0};
        vt[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0040, 32'h0,         1'b0, 1, 32'h0000_00A5, 32'h8000_F0A5, 0};
        vt[2]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0042, 32'h0,         1'b0, 1, 32'hFFFF_8000, 32'h8000_F0A5, 0};
        vt[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0042, 32'h0,         1'b0, 1, 32'h0000_8000, 32'h8000_F0A5, 0};
        vt[4]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0041, 32'h1234_5677, 1'b0, 2, 32'h0000_8000, 32'h8000_77A5, 1};
        vt[5]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1, 32'h0000_8000, 32'hDEAD_BEEF, 1};
        vt[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0,         1'b0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
        vt[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0042, 32'h0,         1'b1, 0, 32'hDEAD_BEEF, 32'h8000_77A5, 0};
        vt[8]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0043, 32'h0000_FFFF, 1'b1, 0, 32'hDEAD_BEEF, 32'h8000_77A5, 0};
        vt[9]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 0, 32'hDEAD_BEEF, 32'h8000_77A5, 0};
        vt[10] = '{1'b1, 2'd3, 1'b0, 32'h0000_0044, 32'h0,         1'b1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
        vt[11] = '{1'b1, 2'd1, 1'b0, 32'h0000_0046, 32'h1234_CAFE, 1'b0, 2, 32'hDEAD_BEEF, 32'hCAFE_BEEF, 1};
        vt[12] = '{1'b0, 2'd1, 1'b0, 32'h0000_0046, 32'h0,         1'b0, 1, 32'hFFFF_CAFE, 32'hCAFE_BEEF, 0};
        vt[13] = '{1'b0, 2'd0, 1'b0, 32'h0000_0047, 32'h0,         1'b0, 1, 32'hFFFF_FFCA, 32'hCAFE_BEEF, 0};
        vt[14] = '{1'b0, 2'd0, 1'b1, 32'h0000_0045, 32'h0,         1'b0, 1, 32'h0000_00BE, 32'hCAFE_BEEF, 0};
        vt[15] = '{1'b1, 2'd0, 1'b0, 32'h0000_0043, 32'h0000_00FF, 1'b0, 2, 32'h0000_00BE, 32'hFF00_77A5, 1};
        vt[16] = '{1'b0, 2'd0, 1'b0, 32'h0000_1043, 32'h0,         1'b0, 1, 32'hFFFF_FFFF, 32'hFF00_77A5, 0};
        vt[17] = '{1'b0, 2'd2, 1'b1, 32'hFFFF_F044, 32'h0,         1'b0, 1, 32'hCAFE_BEEF, 32'hCAFE_BEEF, 0};
        vt[18] = '{1'b0, 2'd1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 1, 32'h0000_77A5, 32'hFF00_77A5, 0};
        vt[19] = '{1'b1, 2'd0, 1'b0, 32'h0000_0042, 32'h0000_00AB, 1'b0, 2, 32'h0000_77A5, 32'hFFAB_77A5, 1};

        // Asynchronous reset takes effect before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_busy",   {31'b0, busy},   32'h0);
        check("rst_done",   {31'b0, done},   32'h0);
        check("rst_err",    {31'b0, err},    32'h0);
        check("rst_rdata",  rdata,           32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_A",  32'(mem_A),      32'h0);
        check("rst_mem_WD", mem_WD,          32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_rdata = '0;

        for (int i = 16; i < 32; i++)
            preload(i, $urandom());
        preload(16, 32'h8000_F0A5);
        preload(17, 32'h0000_0000);
        preload(18, 32'h1122_3344);

        for (int i = 0; i < 20; i++) begin
            model_op(vt[i].w, vt[i].s, vt[i].u, vt[i].a, vt[i].d, me, mlat, mwe);
            do_op(vt[i].w, vt[i].s, vt[i].u, vt[i].a, vt[i].d, lat, e, rd, wec, we_at);
            check($sformatf("vec%0d_err", i),   {31'b0, e},  {31'b0, vt[i].e});
            check($sformatf("vec%0d_lat", i),   32'(lat),    32'(vt[i].lat));
            check($sformatf("vec%0d_rdata", i), rd,          vt[i].rd);
            check($sformatf("vec%0d_word", i),  ram[vt[i].a[11:2]], vt[i].word);
            check($sformatf("vec%0d_we", i),    32'(wec),    32'(vt[i].we));
            if (vt[i].we != 0)
                check($sformatf("vec%0d_we_cycle", i), 32'(we_at), 32'(vt[i].lat - 1));
            check($sformatf("vec%0d_idle", i),  {31'b0, busy}, 32'h0);
        end

        // Reset while a byte store sits in WRITE: write must be dropped
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h48; wdata = 32'h55;
        @(posedge clk);
        #1 req = 1'b0;
        check("rmw_busy_read", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1;
        check("rmw_we_write", {31'b0, mem_we}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_we",    {31'b0, mem_we}, 32'h0);
        check("abort_busy",  {31'b0, busy},   32'h0);
        check("abort_done",  {31'b0, done},   32'h0);
        check("abort_rdata", rdata,           32'h0);
        check("abort_mem_A", 32'(mem_A),      32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_rdata = '0;
        check("abort_ram", ram[18], 32'h1122_3344);
        do_op(1'b0, 2'd2, 1'b0, 32'h48, 32'h0, lat, e, rd, wec, we_at);
        check("post_abort_err",   {31'b0, e}, 32'h0);
        check("post_abort_lat",   32'(lat),   32'd1);
        check("post_abort_rdata", rd,         32'h1122_3344);
        m_rdata = 32'h1122_3344;

        // Request held high: loads accepted once every three cycles
        @(negedge clk);
        req = 1'b1; wr = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h44;
        prev = 1'b0; acc = 0; dcnt = 0; acc_mask = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (busy && !prev) begin
                acc++;
                acc_mask[c] = 1'b1;
            end
            if (done) dcnt++;
            prev = busy;
        end
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_accepts", 32'(acc), 32'd4);
        check("held_pattern", {22'b0, acc_mask}, 32'h249);
        check("held_dones", 32'(dcnt), 32'd3);
        check("held_rdata", rdata, model_word(32'h44));
        m_rdata = model_word(32'h44);

        // Randomized traffic within words 0x10..0x1F, with random high address bits
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            s = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a = ($urandom() & 32'hFFFF_F03F) | 32'h0000_0040;
            d = $urandom();
            model_op(w, s, u, a, d, me, mlat, mwe);
            do_op(w, s, u, a, d, lat, e, rd, wec, we_at);
            check($sformatf("rnd%0d_err", n),   {31'b0, e}, {31'b0, me});
            check($sformatf("rnd%0d_lat", n),   32'(lat),   32'(mlat));
            check($sformatf("rnd%0d_rdata", n), rd,         m_rdata);
            check($sformatf("rnd%0d_word", n),  ram[a[11:2]], model_word(a));
            check($sformatf("rnd%0d_we", n),    32'(wec),   32'(mwe));
        end

        check("err_only_with_done", 32'(err_nodone), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
